// File: rtl/lc4_dmem_responder.sv
// LC4 data-memory responder: one request at a time, fixed-latency word memory, one-cycle response.
// Optional privilege check on the upper half of the address space: define LC4_DMEM_PRIV_CHECK_EN.
module lc4_dmem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [15:0] req_wdata,
    input  logic        req_priv,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_fault,
    output logic        busy
);

    localparam int unsigned Depth = 1 << ADDR_BITS;

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("lc4_dmem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        priv_q, priv_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        mem_wr;
    logic        fault;

    logic [15:0]          mem [Depth];
    logic [ADDR_BITS-1:0] idx;

    assign idx = addr_q[ADDR_BITS-1:0];

`ifdef LC4_DMEM_PRIV_CHECK_EN
    assign fault = addr_q[15] & ~priv_q;
`else
    assign fault = 1'b0;
`endif

    // Upper address bits alias; priv only matters with the privilege check built in.
    logic unused_bits;
    assign unused_bits = ^{addr_q, priv_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        priv_d  = priv_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        valid_d = 1'b0;
        mem_wr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    priv_d  = req_priv;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: the memory is touched exactly here.
                    state_d = StResp;
                    valid_d = 1'b1;
                    fault_d = fault;
                    if (fault) begin
                        rdata_d = we_q ? wdata_q : 16'h0000;
                    end else if (we_q) begin
                        mem_wr  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            priv_q  <= 1'b0;
            rdata_q <= 16'h0000;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            priv_q  <= priv_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

endmodule

// File: tb/tb_lc4_dmem_responder.sv
// Self-checking bench for lc4_dmem_responder: vector table, corner sequences, randomized model.
module tb_lc4_dmem_responder;

    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_we;
    logic [15:0] req_wdata;
    logic        req_priv;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_fault;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lc4_dmem_responder #(
        .ADDR_BITS(ADDR_BITS),
        .LATENCY  (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_priv  (req_priv),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        priv;
        logic        chk_rd;
        logic [15:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] model_mem [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_rdata"}, 32'(resp_rdata), 0);
        check({tag, "_resp_fault"}, 32'(resp_fault), 0);
    endtask

    // One complete transaction; leaves the DUT back in idle.
    task automatic txn(input logic [15:0] a, input logic w, input logic [15:0] d, input logic p,
                       output logic [15:0] rd, output logic flt);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_req", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        req_wdata = d;
        req_priv  = p;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_we    = 1'($urandom);
        req_wdata = 16'($urandom);
        req_priv  = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 40);
        check("latency", 32'(lat), 32'(LATENCY));
        rd  = resp_rdata;
        flt = resp_fault;
        @(posedge clk);
        #1;
        check("resp_one_cycle", 32'(resp_valid), 0);
        check("idle_after_resp", 32'(busy), 0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        flt;
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        logic        p;
        logic        exp_flt;
        int unsigned idx;

        vecs.push_back('{16'h0005, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b0});
        vecs.push_back('{16'h0005, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0});
        vecs.push_back('{16'h0403, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 1'b0});
        vecs.push_back('{16'h0003, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0});
        vecs.push_back('{16'hFC03, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0});
        vecs.push_back('{16'h0006, 1'b1, 16'hA5A5, 1'b0, 1'b1, 16'hA5A5, 1'b0});
        vecs.push_back('{16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0});
`ifdef LC4_DMEM_PRIV_CHECK_EN
        vecs.push_back('{16'h8000, 1'b1, 16'h0077, 1'b1, 1'b1, 16'h0077, 1'b0});
        vecs.push_back('{16'h8000, 1'b1, 16'h00FF, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0077, 1'b0});
`endif

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_we    = 1'b0;
        req_wdata = 16'h0000;
        req_priv  = 1'b0;
        #12;
        check_idle_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].priv, rd, flt);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].exp_fault));
        end

        // Asynchronous reset while idle with a non-zero rdata held.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_reset("idle_reset");
        @(negedge clk);
        rst = 1'b0;

        // Request held valid with changing address: only the idle-cycle one is served.
        txn(16'h0020, 1'b1, 16'h1111, 1'b1, rd, flt);
        txn(16'h0021, 1'b1, 16'h2222, 1'b1, rd, flt);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_priv  = 1'b1;
        req_addr  = 16'h0020;
        @(posedge clk);
        for (int j = 0; j <= int'(LATENCY) + 1; j++) begin
            @(negedge clk);
            if (j <= int'(LATENCY)) begin
                check($sformatf("hold_ready_j%0d", j), 32'(req_ready), 0);
                check($sformatf("hold_resp_j%0d", j), 32'(resp_valid), 32'(j == int'(LATENCY)));
                if (j == int'(LATENCY)) check("hold_rdata_first", 32'(resp_rdata), 32'h1111);
                req_addr = 16'h0040 + 16'(j);
            end else begin
                check("hold_ready_again", 32'(req_ready), 1);
                req_addr = 16'h0021;
            end
        end
        @(posedge clk);
        for (int j = int'(LATENCY) + 2; j <= 2 * int'(LATENCY) + 2; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("hold2_resp_j%0d", j), 32'(resp_valid),
                  32'(j == 2 * int'(LATENCY) + 2));
            if (j == 2 * int'(LATENCY) + 2) check("hold_rdata_second", 32'(resp_rdata), 32'h2222);
        end

        // Reset during WAIT drops the in-flight store.
        txn(16'h0010, 1'b1, 16'h5555, 1'b1, rd, flt);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 16'h0010;
        req_we    = 1'b1;
        req_wdata = 16'hAAAA;
        req_priv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_idle_reset("wait_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < int'(LATENCY) + 3; j++) begin
            @(negedge clk);
            check("no_resp_after_rst", 32'(resp_valid), 0);
        end
        txn(16'h0010, 1'b0, 16'h0000, 1'b1, rd, flt);
        check("rst_dropped_store", 32'(rd), 32'h5555);

        // Randomized traffic against an associative-array memory model.
        for (int i = 0; i < 60; i++) begin
            a = (16'($urandom) & ~16'(DEPTH - 1)) | (16'h0100 + 16'($urandom_range(0, 7)));
            d = 16'($urandom);
            w = 1'($urandom);
            p = 1'($urandom);
            idx = int'(a) % DEPTH;
            exp_flt = 1'b0;
`ifdef LC4_DMEM_PRIV_CHECK_EN
            exp_flt = (a >= 16'h8000) && !p;
`endif
            txn(a, w, d, p, rd, flt);
            check("rand_fault", 32'(flt), 32'(exp_flt));
            if (w && !exp_flt) begin
                model_mem[idx] = d;
                check("rand_store_echo", 32'(rd), 32'(d));
            end else if (!w && exp_flt) begin
                check("rand_fault_load", 32'(rd), 0);
            end else if (!w && model_mem.exists(idx)) begin
                check("rand_load", 32'(rd), 32'(model_mem[idx]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc4_dmem_responder.md
Name: lc4_dmem_responder

Overview:
Data-memory responder for the LC4 core: the memory end of the data-side interface that carries address, store data, write-enable and load data. It accepts one load/store request at a time over a valid/ready handshake and models a word-addressed, multi-cycle data memory. It returns load data, or a store acknowledge, through a one-cycle response strobe. It sits between the core's data-path controller and the testbench/top-level memory map and lets stall logic be exercised against a non-zero-latency memory.

Parameters:
ADDR_BITS, 10, number of word-index bits; depth = 2^ADDR_BITS 16-bit words
LATENCY, 2, cycles spent in WAIT per request; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  16  word address of the access
req_we  input  1  1 = store, 0 = load
req_wdata  input  16  store data
req_priv  input  1  requester privilege bit (used only with the optional feature)
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  16  load data, or echoed store data for stores
resp_fault  output  1  access rejected (optional feature only), qualified by resp_valid
busy  output  1  request in flight (state != IDLE); drives the core stall

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, resp_valid=0, resp_rdata=16'h0000, resp_fault=0, captured request regs=0. Memory array is not cleared.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE. busy=1 in WAIT and RESP.
- IDLE: accept on req_valid && req_ready at a rising edge. Capture addr, we, wdata and priv. Load counter with LATENCY-1. Go to WAIT.
- IDLE with req_valid=0: stay in IDLE.
- WAIT: if counter != 0, decrement it. If counter == 0, this edge is the access edge; go to RESP.
- Access edge, store: mem[addr[ADDR_BITS-1:0]] <= wdata; resp_rdata <= wdata.
- Access edge, load: resp_rdata <= mem[addr[ADDR_BITS-1:0]].
- RESP: resp_valid=1 for exactly this one cycle, then IDLE unconditionally. resp_rdata holds its value until the next access edge.
- Latency: if a request is accepted at edge k, resp_valid is high between edges k+LATENCY and k+LATENCY+1. Minimum request spacing is LATENCY+2 cycles.
- req_valid and request inputs while in WAIT/RESP: ignored and not queued. The captured copy is used.
- Addressing: upper 16-ADDR_BITS address bits are ignored, so addresses alias modulo 2^ADDR_BITS.
- Store then load to the same address: the load returns the new value.
- Reset mid-operation: the in-flight request is dropped. If reset arrives before the access edge, no write occurs. No response is issued.
- LATENCY outside 1..15 is a configuration error. The implementation includes an elaboration-time check.

Optional Feature:
- Macro: LC4_DMEM_PRIV_CHECK_EN.
- Defined: a captured request with addr >= 16'h8000 and priv=0 makes no memory access. A faulting store is suppressed; a faulting load returns 16'h0000. resp_fault=1 in its RESP cycle; timing is unchanged.
- Not defined: req_priv is ignored and resp_fault is tied to 0.

Test Plan:
- Reset: rst=1 mid-idle -> req_ready=1, busy=0, resp_valid=0, resp_rdata=16'h0000, resp_fault=0.
- LATENCY=2, store 16'h1234 to 16'h0005 accepted at edge k -> resp_valid high only between edges k+2 and k+3, resp_rdata=16'h1234. Load 16'h0005 -> resp_rdata=16'h1234.
- ADDR_BITS=10, store 16'hBEEF to 16'h0403 -> load 16'h0003 returns 16'hBEEF.
- Hold req_valid=1 with a changing addr through WAIT/RESP -> req_ready=0 and only the IDLE-cycle request is served. The next request is accepted LATENCY+2 cycles after the first.
- Store 16'h5555 to 16'h0010, then store 16'hAAAA to 16'h0010 with rst pulsed during WAIT -> no resp_valid; subsequent load returns 16'h5555.
- With LC4_DMEM_PRIV_CHECK_EN: priv=1 store 16'h0077 to 16'h8000, then priv=0 store 16'h00FF to 16'h8000 -> second response has resp_fault=1. Priv=0 load of 16'h8000 -> resp_rdata=16'h0000, resp_fault=1. Priv=1 load of 16'h8000 -> 16'h0077, resp_fault=0.
